// File: rtl/bp_pkg.sv
// Shared definitions for the gshare direction predictor: counter encoding,
// hash selectors, FSM state type and the 2-bit saturating counter update.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int HASH_CONCAT = 0;
  localparam int HASH_XOR    = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_gshare_if.sv
// Pipeline-facing signal bundle of the gshare predictor.
interface branch_predict_gshare_if;
  // The pipeline (master) drives stage controls, the F-stage PC/branch flags and
  // the M-stage resolution every cycle; there is no handshake, each cycle's
  // values are consumed at the next clock edge. The predictor (slave) returns
  // the registered D-stage prediction and the init status.
  logic        stallD;
  logic        flushD;
  logic        flushE;
  logic        flushM;
  logic [31:0] pcF;
  logic        branchD;
  logic        pred_takeD;
  logic [31:0] pcM;
  logic        branchM;
  logic        actual_takeM;
  logic        pred_takeM;
  logic        init_done;

  modport master (
    output stallD, flushD, flushE, flushM, pcF, branchD,
    output pcM, branchM, actual_takeM, pred_takeM,
    input  pred_takeD, init_done
  );

  modport slave (
    input  stallD, flushD, flushE, flushM, pcF, branchD,
    input  pcM, branchM, actual_takeM, pred_takeM,
    output pred_takeD, init_done
  );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W two-bit counters, no reset so it maps to LUT RAM.
// One async lookup port plus a read-modify-write port (write + read of the same address).
module bp_pht #(
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [1:0]       rdata_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [1:0]       wdata_i,
  output logic [1:0]       wold_o
);

  logic [1:0] mem_q [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Reads see the pre-write contents, so a same-cycle lookup returns the old value.
  assign rdata_o = mem_q[raddr_i];
  assign wold_o  = mem_q[waddr_i];

endmodule

// File: rtl/branch_predict_gshare.sv
// gshare direction predictor: PHT indexed by PC hashed with speculative history,
// init sweep FSM, M-stage repair. Optional counters under `BP_STATS_EN`.
module branch_predict_gshare
  import bp_pkg::*;
#(
  parameter int         IDX_W     = 12,
  parameter int         GHR_W     = 8,
  parameter int         HASH_MODE = 1,
  parameter int         PC_LSB    = 2,
  parameter logic [1:0] INIT_CTR  = 2'b10
) (
  input  logic clk,
  input  logic rst,
  branch_predict_gshare_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0] ghr_spec_q, ghr_spec_d, ghr_commit_q, ghr_commit_d;
  logic [GHR_W-1:0] ghr_d_q, ghr_e_q, ghr_m_q;
  logic             pred_f_q;
  logic             run, init_we, mispredict, d_shift, pht_we;
  logic [IDX_W-1:0] idx_f, idx_m, pht_waddr;
  logic [1:0]       ctr_f, ctr_m, pht_wdata;

  function automatic logic [IDX_W-1:0] hash_idx(input logic [31:0] pc,
                                                input logic [GHR_W-1:0] ghr);
    logic [IDX_W-1:0] field;
    logic [IDX_W-1:0] ghr_ext;
    field   = pc[PC_LSB +: IDX_W];
    ghr_ext = IDX_W'(ghr);
    if (HASH_MODE == HASH_CONCAT) return ((field >> GHR_W) << GHR_W) | ghr_ext;
    return field ^ ghr_ext;
  endfunction

  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] ghr, input logic b);
    return GHR_W'({ghr, b});
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        ptr_d   = ptr_q + IDX_W'(1);
        if (ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign run           = (state_q == ST_RUN);
  assign bp.init_done  = run;
  assign bp.pred_takeD = bp.branchD & pred_f_q & run;

  // M index uses the history carried with the branch, so the update hits the entry it read.
  assign idx_f      = hash_idx(bp.pcF, ghr_spec_q);
  assign idx_m      = hash_idx(bp.pcM, ghr_m_q);
  assign pht_we     = init_we | (run & bp.branchM);
  assign pht_waddr  = run ? idx_m : ptr_q;
  assign pht_wdata  = run ? sat_update(ctr_m, bp.actual_takeM) : INIT_CTR;

  bp_pht #(.IDX_W(IDX_W)) u_pht (
    .clk     (clk),
    .raddr_i (idx_f),
    .rdata_o (ctr_f),
    .we_i    (pht_we),
    .waddr_i (pht_waddr),
    .wdata_i (pht_wdata),
    .wold_o  (ctr_m)
  );

  assign mispredict = run & bp.branchM & (bp.actual_takeM != bp.pred_takeM);
  assign d_shift    = bp.branchD & ~bp.stallD & ~bp.flushD;

  always_comb begin
    ghr_commit_d = ghr_commit_q;
    ghr_spec_d   = ghr_spec_q;
    if (run) begin
      if (bp.branchM) ghr_commit_d = shift_in(ghr_commit_q, bp.actual_takeM);
      // Repair wins over a D-stage shift: that D branch is on the wrong path.
      if (mispredict)   ghr_spec_d = shift_in(ghr_commit_q, bp.actual_takeM);
      else if (d_shift) ghr_spec_d = shift_in(ghr_spec_q, bp.pred_takeD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_spec_q   <= '0;
      ghr_commit_q <= '0;
      pred_f_q     <= 1'b0;
      ghr_d_q      <= '0;
      ghr_e_q      <= '0;
      ghr_m_q      <= '0;
    end else begin
      ghr_spec_q   <= ghr_spec_d;
      ghr_commit_q <= ghr_commit_d;
      if (bp.flushD) begin
        pred_f_q <= 1'b0;
        ghr_d_q  <= '0;
      end else if (!bp.stallD) begin
        pred_f_q <= ctr_f[1];
        ghr_d_q  <= ghr_spec_q;
      end
      ghr_e_q <= bp.flushE ? '0 : ghr_d_q;
      ghr_m_q <= bp.flushM ? '0 : ghr_e_q;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (run) begin
      if (bp.branchM && stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_gshare.sv
// Bench for branch_predict_gshare (IDX_W=6, GHR_W=5, XOR hash): directed
// init/training/repair/flush scenarios plus random traffic against a reference model.
module tb_branch_predict_gshare;

  localparam int         IDX_W     = 6;
  localparam int         GHR_W     = 5;
  localparam int         HASH_MODE = 1;
  localparam int         PC_LSB    = 2;
  localparam logic [1:0] INIT_CTR  = 2'b10;
  localparam int         N_ENT     = 1 << IDX_W;
  localparam int         N_GHR     = 1 << GHR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_gshare_if bp_if ();
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predict_gshare #(
    .IDX_W(IDX_W), .GHR_W(GHR_W), .HASH_MODE(HASH_MODE), .PC_LSB(PC_LSB), .INIT_CTR(INIT_CTR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Counter values held as 0..3; -1 marks an entry never written since time zero.
  int m_pht [N_ENT];
  int m_cnt = 0, m_run = 0, m_pred_f = 0;
  int m_spec = 0, m_commit = 0, m_gd = 0, m_ge = 0, m_gm = 0;
  longint m_sb = 0, m_sm = 0;
  int t_idx_f, t_idx_m, t_look, t_pd, t_mis, t_newc;

  initial foreach (m_pht[i]) m_pht[i] = -1;

  function automatic int m_index(input logic [31:0] pc, input int g);
    int field;
    field = int'((pc >> PC_LSB) % N_ENT);
    if (HASH_MODE == 1) return field ^ g;
    return (field / N_GHR) * N_GHR + g;
  endfunction

  function automatic int m_sat(input int c, input int taken);
    if (taken != 0) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic int m_push(input int g, input int b);
    return (g * 2 + b) % N_GHR;
  endfunction

  // Expected pred_takeD for the current inputs; -1 when it depends on an unwritten entry.
  function automatic int m_exp_pred();
    if (m_run == 0 || bp_if.branchD !== 1'b1) return 0;
    return m_pred_f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_run = 0; m_pred_f = 0;
      m_spec = 0; m_commit = 0; m_gd = 0; m_ge = 0; m_gm = 0;
      m_sb = 0; m_sm = 0;
    end else begin
      t_idx_f = m_index(bp_if.pcF, m_spec);
      t_idx_m = m_index(bp_if.pcM, m_gm);
      t_look  = (m_pht[t_idx_f] < 0) ? -1 : m_pht[t_idx_f] / 2;
      t_pd    = m_exp_pred();
      t_mis   = (m_run != 0 && bp_if.branchM && bp_if.actual_takeM != bp_if.pred_takeM) ? 1 : 0;
      m_gm = bp_if.flushM ? 0 : m_ge;
      m_ge = bp_if.flushE ? 0 : m_gd;
      if (bp_if.flushD) begin
        m_gd = 0; m_pred_f = 0;
      end else if (!bp_if.stallD) begin
        m_gd = m_spec; m_pred_f = t_look;
      end
      if (m_run != 0) begin
        t_newc = m_commit;
        if (bp_if.branchM) begin
          m_pht[t_idx_m] = m_sat(m_pht[t_idx_m], int'(bp_if.actual_takeM));
          t_newc = m_push(m_commit, int'(bp_if.actual_takeM));
          if (m_sb < 64'hFFFF_FFFF) m_sb++;
        end
        if (t_mis != 0) begin
          m_spec = t_newc;
          if (m_sm < 64'hFFFF_FFFF) m_sm++;
        end else if (bp_if.branchD && !bp_if.stallD && !bp_if.flushD) begin
          m_spec = m_push(m_spec, (t_pd > 0) ? 1 : 0);
        end
        m_commit = t_newc;
      end else begin
        m_pht[m_cnt] = int'(INIT_CTR);
        if (m_cnt == N_ENT - 1) m_run = 1;
        m_cnt++;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int e;
    chk("init_done", int'(bp_if.init_done), m_run);
    e = m_exp_pred();
    if (e >= 0) chk("pred_takeD", int'(bp_if.pred_takeD), e);
`ifdef BP_STATS_EN
    chk("stat_branches", int'(stat_branches), int'(m_sb));
    chk("stat_mispredicts", int'(stat_mispredicts), int'(m_sm));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    bp_if.stallD = 1'b0; bp_if.flushD = 1'b0; bp_if.flushE = 1'b0; bp_if.flushM = 1'b0;
    bp_if.pcF = '0; bp_if.branchD = 1'b0;
    bp_if.pcM = '0; bp_if.branchM = 1'b0; bp_if.actual_takeM = 1'b0; bp_if.pred_takeM = 1'b0;
  endtask

  // Load pred_F from pc, then look at it with D stalled so history is not disturbed.
  task automatic observe(input string name, input logic [31:0] pc, input int exp);
    bp_if.pcF = pc;
    tick();
    bp_if.stallD = 1'b1; bp_if.branchD = 1'b1;
    #1;
    chk(name, int'(bp_if.pred_takeD), exp);
    tick();
    bp_if.stallD = 1'b0; bp_if.branchD = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic act, input logic pred);
    bp_if.pcM = pc; bp_if.branchM = 1'b1; bp_if.actual_takeM = act; bp_if.pred_takeM = pred;
    tick();
    bp_if.branchM = 1'b0;
  endtask

  task automatic drive_random();
    bp_if.pcF          = $urandom;
    bp_if.branchD      = 1'($urandom_range(0, 1));
    bp_if.stallD       = ($urandom_range(0, 4) == 0);
    bp_if.flushD       = ($urandom_range(0, 9) == 0);
    bp_if.flushE       = ($urandom_range(0, 9) == 0);
    bp_if.flushM       = ($urandom_range(0, 9) == 0);
    bp_if.pcM          = {24'h0, 8'($urandom_range(0, 255))};
    bp_if.branchM      = ($urandom_range(0, 9) < 4);
    bp_if.actual_takeM = 1'($urandom_range(0, 1));
    bp_if.pred_takeM   = ($urandom_range(0, 3) == 0) ? ~bp_if.actual_takeM : bp_if.actual_takeM;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (20) tick();
    rst = 1'b0;                       // restart the sweep part way through
    tick();
    rst = 1'b1;
    bp_if.branchD = 1'b1;             // prediction must stay low throughout the sweep
    bp_if.pcF = 32'h3C;
    repeat (63) tick();
    chk("init_done_after_63", int'(bp_if.init_done), 0);
    tick();
    chk("init_done_after_64", int'(bp_if.init_done), 1);
    bp_if.branchD = 1'b0;
    tick();

    // Training at pc 0x100 (index 0, history stays 0 because predictions always match)
    observe("fresh_entry_weak_taken", 32'h100, 1);
    repeat (3) resolve(32'h100, 1'b1, 1'b1);
    observe("after_3_taken", 32'h100, 1);
    resolve(32'h100, 1'b0, 1'b0);
    observe("strong_to_weak_taken", 32'h100, 1);
    resolve(32'h100, 1'b0, 1'b0);
    observe("weak_taken_to_weak_nt", 32'h100, 0);

    // Drive entry 3 to strong-NT, then build committed history ending 1001
    repeat (2) resolve(32'h00C, 1'b0, 1'b0);
    resolve(32'h1F0, 1'b1, 1'b1);
    resolve(32'h1F0, 1'b0, 1'b0);
    resolve(32'h1F0, 1'b0, 1'b0);
    resolve(32'h1F0, 1'b1, 1'b1);

    // Mispredict with a D-stage branch in the same cycle: history becomes 0x13
    bp_if.branchD = 1'b1;
    resolve(32'h1F0, 1'b1, 1'b0);
    bp_if.branchD = 1'b0;
    bp_if.pcF = 32'h40;
    repeat (2) tick();
    observe("xor_index_3_strong_nt", 32'h40, 0);   // 0x10 ^ 0x13 = 0x03
    repeat (2) resolve(32'h40, 1'b1, 1'b1);        // update lands on index 3 too
    observe("xor_update_index_3", 32'h40, 1);

    // flushD clears the registered prediction
    bp_if.pcF = 32'h40;
    tick();
    bp_if.flushD = 1'b1;
    tick();
    bp_if.flushD = 1'b0; bp_if.stallD = 1'b1; bp_if.branchD = 1'b1;
    #1;
    chk("flushD_clears_pred", int'(bp_if.pred_takeD), 0);
    tick();
    drive_idle();

    // Random traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      if (i == 1500) rst = 1'b0;
      if (i == 1503) rst = 1'b1;
      tick();
    end
    drive_idle();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
